// File: rtl/mips_wb_stage_p_pkg.sv
// Shared definitions for the MIPS32 write-back stage: instruction-type codes,
// the halt FSM state encoding and the bit positions of the rd/rt fields.
package mips_pipe_pkg;

   localparam int TYPE_W = 3;

   // rd = ins[RD_LSB +: REG_AW], rt = ins[RT_LSB +: REG_AW]
   localparam int RD_LSB = 11;
   localparam int RT_LSB = 16;

   typedef enum logic [TYPE_W-1:0] {
      T_RR_ALU = 3'd0,
      T_RI_ALU = 3'd1,
      T_LOAD   = 3'd2,
      T_STORE  = 3'd3,
      T_BRANCH = 3'd4,
      T_HALT   = 3'd5
   } wb_type_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } wb_state_e;

endpackage

// File: rtl/mips_wb_stage_p_if.sv
// MEM/WB -> register-file bundle for the write-back stage.
// The statistics counters exist only when WB_STATS_EN is defined.
interface mips_wb_stage_p_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int TYPE_W = mips_pipe_pkg::TYPE_W,
   parameter int CNT_W  = 32
);
   logic              valid45;
   logic              branch_f;
   logic [DATA_W-1:0] ins45;
   logic [DATA_W-1:0] aluout45;
   logic [DATA_W-1:0] tld45;
   logic [TYPE_W-1:0] type45;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              halt_f;
`ifdef WB_STATS_EN
   logic [CNT_W-1:0]  retired_cnt;
   logic [CNT_W-1:0]  squash_cnt;
`endif

   modport master (
      output valid45, branch_f, ins45, aluout45, tld45, type45,
      input  wb_en, wb_addr, wb_data, halt_f
`ifdef WB_STATS_EN
      , input retired_cnt, squash_cnt
`endif
   );

   modport slave (
      input  valid45, branch_f, ins45, aluout45, tld45, type45,
      output wb_en, wb_addr, wb_data, halt_f
`ifdef WB_STATS_EN
      , output retired_cnt, squash_cnt
`endif
   );

endinterface

// File: rtl/mips_wb_stage_p_dest_sel.sv
// Combinational decode of instruction type into write intent, destination
// register and data source (ALU result or load data).
module mips_wb_dest_sel #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int TYPE_W = mips_pipe_pkg::TYPE_W
) (
   input  logic [DATA_W-1:0] i_ins,
   input  logic [TYPE_W-1:0] i_type,
   output logic              o_writes,
   output logic [REG_AW-1:0] o_addr,
   output logic              o_sel_load,
   output logic              o_halt
);
   import mips_pipe_pkg::*;

   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_rt;

   assign w_rd = i_ins[RD_LSB +: REG_AW];
   assign w_rt = i_ins[RT_LSB +: REG_AW];

   // Type decode; unknown codes fall through as non-writers.
   always_comb begin
      o_writes   = 1'b0;
      o_addr     = '0;
      o_sel_load = 1'b0;
      o_halt     = 1'b0;
      case (i_type)
         TYPE_W'(T_RR_ALU): begin o_writes = 1'b1; o_addr = w_rd; end
         TYPE_W'(T_RI_ALU): begin o_writes = 1'b1; o_addr = w_rt; end
         TYPE_W'(T_LOAD):   begin o_writes = 1'b1; o_addr = w_rt; o_sel_load = 1'b1; end
         TYPE_W'(T_HALT):   o_halt = 1'b1;
         default:           o_writes = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_wb_stage_p.sv
// MIPS32 write-back stage: registered register-file write port with valid /
// squash qualification, r0 write suppression and a sticky RUN/HALTED FSM.
// Optional feature macro: WB_STATS_EN (retired / squashed instruction counters).
module mips_wb_stage_p #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int TYPE_W = mips_pipe_pkg::TYPE_W,
   parameter int CNT_W  = 32
) (
   input  logic           clk,
   input  logic           rst,
   mips_wb_stage_p_if.slave wb_if
);
   import mips_pipe_pkg::*;

   wb_state_e         r_state;
   logic              r_wb_en;
   logic [REG_AW-1:0] r_wb_addr;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_halt_f;

   logic              w_writes;
   logic [REG_AW-1:0] w_addr;
   logic              w_sel_load;
   logic              w_is_halt;
   logic              w_accept;
   logic              w_squash;
   logic              w_do_write;
   logic [DATA_W-1:0] w_data;

   mips_wb_dest_sel #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .TYPE_W (TYPE_W)
   ) u_dest_sel (
      .i_ins      (wb_if.ins45),
      .i_type     (wb_if.type45),
      .o_writes   (w_writes),
      .o_addr     (w_addr),
      .o_sel_load (w_sel_load),
      .o_halt     (w_is_halt)
   );

   assign w_accept   = (r_state == ST_RUN) && wb_if.valid45 && !wb_if.branch_f;
   assign w_squash   = (r_state == ST_RUN) && wb_if.valid45 &&  wb_if.branch_f;
   assign w_do_write = w_accept && w_writes && (w_addr != '0);
   assign w_data     = w_sel_load ? wb_if.tld45 : wb_if.aluout45;

   // Halt FSM and write port; address/data only move on an actual write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
         r_halt_f  <= 1'b0;
      end else begin
         r_wb_en <= w_do_write;
         if (w_do_write) begin
            r_wb_addr <= w_addr;
            r_wb_data <= w_data;
         end
         case (r_state)
            ST_RUN: begin
               if (w_accept && w_is_halt) begin
                  r_state  <= ST_HALTED;
                  r_halt_f <= 1'b1;
               end
            end
            default: r_state <= ST_HALTED;
         endcase
      end
   end

   assign wb_if.wb_en   = r_wb_en;
   assign wb_if.wb_addr = r_wb_addr;
   assign wb_if.wb_data = r_wb_data;
   assign wb_if.halt_f  = r_halt_f;

`ifdef WB_STATS_EN
   logic [CNT_W-1:0] r_retired_cnt;
   logic [CNT_W-1:0] r_squash_cnt;

   // Statistics; both counters freeze once halted because accept/squash need RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired_cnt <= '0;
         r_squash_cnt  <= '0;
      end else begin
         if (w_accept) r_retired_cnt <= r_retired_cnt + 1'b1;
         if (w_squash) r_squash_cnt  <= r_squash_cnt + 1'b1;
      end
   end

   assign wb_if.retired_cnt = r_retired_cnt;
   assign wb_if.squash_cnt  = r_squash_cnt;
`endif

endmodule

// File: tb/tb_mips_wb_stage_p.sv
// Self-checking bench for mips_wb_stage_p: directed scenarios plus randomized
// traffic against a behavioural model of the write-back rules.
module tb_mips_wb_stage_p;
   import mips_pipe_pkg::*;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int TW     = 3;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_wb_stage_p_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TYPE_W(TW), .CNT_W(CNT_W)) wb_if ();

   mips_wb_stage_p #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TYPE_W(TW), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .wb_if (wb_if.slave)
   );

   // Behavioural model state
   bit          m_halted;
   bit          m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_ret;
   int          m_sq;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] mk_ins(input int rd, input int rt);
      logic [31:0] r;
      r = $urandom;
      r = (r & 32'hFC00_07FF) | (32'(rt & 31) << 16) | (32'(rd & 31) << 11);
      return r;
   endfunction

   task automatic model_reset();
      m_halted = 0; m_en = 0; m_addr = '0; m_data = '0; m_ret = 0; m_sq = 0;
   endtask

   // Drive one instruction on the negative edge, advance the model at the
   // rising edge, then leave time at posedge+1 for sampling.
   task automatic step(input bit v, input bit br, input logic [31:0] ins,
                       input logic [31:0] alu, input logic [31:0] tld, input int ty);
      int dest;
      bit wr;
      logic [31:0] d;
      @(negedge clk);
      wb_if.valid45  = v;
      wb_if.branch_f = br;
      wb_if.ins45    = ins;
      wb_if.aluout45 = alu;
      wb_if.tld45    = tld;
      wb_if.type45   = 3'(ty);
      @(posedge clk);
      wr = 0; dest = 0; d = '0;
      if (!m_halted && v && br) m_sq++;
      if (!m_halted && v && !br) begin
         m_ret++;
         case (ty)
            0: begin wr = 1; dest = (ins >> 11) & 31; d = alu; end
            1: begin wr = 1; dest = (ins >> 16) & 31; d = alu; end
            2: begin wr = 1; dest = (ins >> 16) & 31; d = tld; end
            5: m_halted = 1;
            default: wr = 0;
         endcase
      end
      m_en = wr && (dest != 0);
      if (m_en) begin m_addr = 5'(dest); m_data = d; end
      #1;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, '0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      wb_if.valid45 = 0; wb_if.branch_f = 0; wb_if.ins45 = '0;
      wb_if.aluout45 = '0; wb_if.tld45 = '0; wb_if.type45 = '0;
      model_reset();
      #2;
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f} !== 39'd0)
         $display("FAIL reset_outputs: got en=%0b addr=%0d data=%h halt=%0b, expected all zero",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f);
      else n_pass++;
`ifdef WB_STATS_EN
      n_checks++;
      if ({wb_if.retired_cnt, wb_if.squash_cnt} !== '0)
         $display("FAIL reset_counters: got ret=%0d sq=%0d, expected 0", wb_if.retired_cnt, wb_if.squash_cnt);
      else n_pass++;
`endif
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_rr_alu();
      step(1, 0, mk_ins(7, 2), 32'h1234, 32'h5555, 0);
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data} !== {1'b1, 5'd7, 32'h1234})
         $display("FAIL rr_write: got en=%0b addr=%0d data=%h, expected en=1 addr=7 data=1234",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data);
      else n_pass++;
      idle();
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data} !== {1'b0, 5'd7, 32'h1234})
         $display("FAIL rr_one_shot: got en=%0b addr=%0d data=%h, expected en=0 addr=7 data=1234",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      step(1, 0, mk_ins(9, 3), 32'hA, 32'h1111, 1);
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data} !== {1'b1, 5'd3, 32'hA})
         $display("FAIL b2b_ri: got en=%0b addr=%0d data=%h, expected en=1 addr=3 data=a",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data);
      else n_pass++;
      step(1, 0, mk_ins(0, 4), 32'h2222, 32'hDEADBEEF, 2);
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data} !== {1'b1, 5'd4, 32'hDEADBEEF})
         $display("FAIL b2b_load: got en=%0b addr=%0d data=%h, expected en=1 addr=4 data=deadbeef",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data);
      else n_pass++;
   endtask

   task automatic test_no_write();
      int types[3] = '{0, 3, 4};
      for (int i = 0; i < 3; i++) begin
         step(1, 0, mk_ins(0, 6), 32'h7777, 32'h8888, types[i]);
         n_checks++;
         if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data} !== {1'b0, 5'd4, 32'hDEADBEEF})
            $display("FAIL no_write_type%0d: got en=%0b addr=%0d data=%h, expected en=0 addr=4 data=deadbeef",
                     types[i], wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data);
         else n_pass++;
      end
   endtask

   task automatic test_squash();
      step(1, 1, mk_ins(1, 5), 32'h1, 32'hCAFE, 2);
      step(1, 1, mk_ins(0, 0), 32'h0, 32'h0, 5);
      n_checks++;
      if ({wb_if.wb_en, wb_if.halt_f, wb_if.wb_addr} !== {1'b0, 1'b0, 5'd4})
         $display("FAIL squash: got en=%0b halt=%0b addr=%0d, expected en=0 halt=0 addr=4",
                  wb_if.wb_en, wb_if.halt_f, wb_if.wb_addr);
      else n_pass++;
`ifdef WB_STATS_EN
      n_checks++;
      if (wb_if.squash_cnt !== 4'd2 || wb_if.retired_cnt !== 4'd6)
         $display("FAIL squash_counters: got sq=%0d ret=%0d, expected sq=2 ret=6",
                  wb_if.squash_cnt, wb_if.retired_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 200; i++) begin
         int ty;
         ty = $urandom_range(0, 6);
         if (ty == 5) ty = 7;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
              mk_ins($urandom_range(0, 31), $urandom_range(0, 31)), $urandom, $urandom, ty);
         n_checks++;
         if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f} !== {m_en, m_addr, m_data, m_halted}) begin
            if (errs < 10)
               $display("FAIL random_cycle%0d: got en=%0b addr=%0d data=%h halt=%0b, expected en=%0b addr=%0d data=%h halt=%0b",
                        i, wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f,
                        m_en, m_addr, m_data, m_halted);
            errs++;
         end else n_pass++;
      end
`ifdef WB_STATS_EN
      n_checks++;
      if (wb_if.retired_cnt !== CNT_W'(m_ret) || wb_if.squash_cnt !== CNT_W'(m_sq))
         $display("FAIL random_counters: got ret=%0d sq=%0d, expected ret=%0d sq=%0d",
                  wb_if.retired_cnt, wb_if.squash_cnt, CNT_W'(m_ret), CNT_W'(m_sq));
      else n_pass++;
`endif
   endtask

   task automatic test_halt();
      logic [CNT_W-1:0] exp_ret;
      step(1, 0, mk_ins(0, 0), 32'h0, 32'h0, 5);
      n_checks++;
      if ({wb_if.halt_f, wb_if.wb_en} !== 2'b10)
         $display("FAIL halt_enter: got halt=%0b en=%0b, expected halt=1 en=0", wb_if.halt_f, wb_if.wb_en);
      else n_pass++;
      exp_ret = CNT_W'(m_ret);
      for (int i = 0; i < 4; i++) begin
         step(1, i[0], mk_ins(9, 9), 32'h9999, 32'h9999, i[1] ? 2 : 0);
         n_checks++;
         if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f} !== {m_en, m_addr, m_data, 1'b1})
            $display("FAIL halt_frozen%0d: got en=%0b addr=%0d data=%h halt=%0b, expected en=0 addr=%0d data=%h halt=1",
                     i, wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f, m_addr, m_data);
         else n_pass++;
      end
`ifdef WB_STATS_EN
      n_checks++;
      if (wb_if.retired_cnt !== exp_ret || wb_if.squash_cnt !== CNT_W'(m_sq))
         $display("FAIL halt_counters: got ret=%0d sq=%0d, expected ret=%0d sq=%0d",
                  wb_if.retired_cnt, wb_if.squash_cnt, exp_ret, CNT_W'(m_sq));
      else n_pass++;
`endif
      #2;
      rst = 1;
      #1;
      n_checks++;
      if (wb_if.halt_f !== 1'b0)
         $display("FAIL halt_async_clear: got halt=%0b, expected 0", wb_if.halt_f);
      else n_pass++;
      model_reset();
      @(negedge clk);
      rst = 0;
      step(1, 0, mk_ins(13, 1), 32'h0D0D, 32'h0, 0);
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f} !== {1'b1, 5'd13, 32'h0D0D, 1'b0})
         $display("FAIL run_after_reset: got en=%0b addr=%0d data=%h halt=%0b, expected en=1 addr=13 data=d0d halt=0",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f);
      else n_pass++;
   endtask

   task automatic test_async_reset_write();
      step(1, 0, mk_ins(11, 0), 32'hBEEF, 32'h0, 0);
      #2;
      rst = 1;
      #1;
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data} !== 38'd0)
         $display("FAIL async_reset_write: got en=%0b addr=%0d data=%h, expected all zero",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data);
      else n_pass++;
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++)
         step(1, 0, mk_ins($urandom_range(0, 31), $urandom_range(0, 31)), $urandom, $urandom,
              $urandom_range(0, 4));
      n_checks++;
      if ({wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, wb_if.halt_f} !== {m_en, m_addr, m_data, m_halted})
         $display("FAIL wrap_outputs: got en=%0b addr=%0d data=%h, expected en=%0b addr=%0d data=%h",
                  wb_if.wb_en, wb_if.wb_addr, wb_if.wb_data, m_en, m_addr, m_data);
      else n_pass++;
`ifdef WB_STATS_EN
      n_checks++;
      if (wb_if.retired_cnt !== 4'd1)
         $display("FAIL wrap_retired: got %0d, expected 1", wb_if.retired_cnt);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_rr_alu();
      test_back_to_back();
      test_no_write();
      test_squash();
      test_random();
      test_halt();
      test_async_reset_write();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
